// File: rtl/key_sequencer.sv
// key_sequencer
//   Operand-entry controller between the keypad encoder and the arithmetic
//   datapath. Detects new key presses, accumulates decimal digits into two
//   unsigned binary operands, records the operator, and on Enter offers one
//   valid/ready command that stays stable until accepted.
//
//   Optional feature macro: KEY_SEQUENCER_CHAIN_EN
//     Adds result/result_valid inputs. A returned result is latched, and an
//     operator pressed before any A digit uses it as operand A.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   keycode      0-9 digit, 10 add, 11 sub, 12 enter, 13/14 unused, 15 multi
//   keystrobe    level, high while a key is held
//   result       (chain build only) datapath result
//   result_valid (chain build only) result strobe
//   cmd_valid    command available
//   cmd_ready    datapath accepts command
//   op_a, op_b   operands, unsigned binary
//   op_sel       0 = add, 1 = sub
//   disp_value   operand currently being entered
//   key_err      one-cycle pulse on a rejected key
module key_sequencer #(
    parameter int NUM_DIGITS = 4,
    parameter int WIDTH      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       keycode,
    input  logic             keystrobe,
`ifdef KEY_SEQUENCER_CHAIN_EN
    input  logic [WIDTH-1:0] result,
    input  logic             result_valid,
`endif
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_sel,
    output logic [WIDTH-1:0] disp_value,
    output logic             key_err
);

    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_DIGITS);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        ISSUE   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             op_sel_q, op_sel_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             key_err_q, key_err_d;
    logic             strobe_q, strobe_d;
`ifdef KEY_SEQUENCER_CHAIN_EN
    logic [WIDTH-1:0] chain_val_q, chain_val_d;
    logic             chain_flag_q, chain_flag_d;
`endif

    logic key_event;
    logic is_digit;
    logic is_op;
    logic is_enter;
    logic digit_ok;

    // x*10 + d as shift-add; the parameter constraint rules out overflow.
    function automatic logic [WIDTH-1:0] mul10_add(input logic [WIDTH-1:0] x,
                                                   input logic [3:0]       d);
        return (x << 3) + (x << 1) + {{(WIDTH-4){1'b0}}, d};
    endfunction

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        count_d     = count_q;
        op_sel_d    = op_sel_q;
        cmd_valid_d = cmd_valid_q;
        key_err_d   = 1'b0;
        strobe_d    = keystrobe;
`ifdef KEY_SEQUENCER_CHAIN_EN
        chain_val_d  = chain_val_q;
        chain_flag_d = chain_flag_q;
`endif

        // Rising edge of the level strobe: a held key yields one event.
        key_event = keystrobe & ~strobe_q;
        is_digit  = (keycode <= 4'd9);
        is_op     = (keycode == 4'd10) || (keycode == 4'd11);
        is_enter  = (keycode == 4'd12);
        digit_ok  = is_digit && (count_q < MAX_CNT);

        case (state_q)
            ENTER_A: begin
                if (key_event) begin
                    if (digit_ok) begin
                        op_a_d  = mul10_add(op_a_q, keycode);
                        count_d = count_q + CNT_W'(1);
`ifdef KEY_SEQUENCER_CHAIN_EN
                        chain_flag_d = 1'b0;
`endif
                    end else if (is_op) begin
                        op_sel_d = keycode[0];
                        count_d  = '0;
                        op_b_d   = '0;
                        state_d  = ENTER_B;
`ifdef KEY_SEQUENCER_CHAIN_EN
                        if ((count_q == '0) && chain_flag_q) begin
                            op_a_d = chain_val_q;
                        end
`endif
                    end else if (!is_enter) begin
                        // Full operand, codes 13-15.
                        key_err_d = 1'b1;
                    end
                end
            end

            ENTER_B: begin
                if (key_event) begin
                    if (digit_ok) begin
                        op_b_d  = mul10_add(op_b_q, keycode);
                        count_d = count_q + CNT_W'(1);
                    end else if (is_op) begin
                        // Last operator pressed wins.
                        op_sel_d = keycode[0];
                    end else if (is_enter) begin
                        cmd_valid_d = 1'b1;
                        state_d     = ISSUE;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end

            ISSUE: begin
                // Keys are dropped here, including one on the handshake edge.
                if (key_event) begin
                    key_err_d = 1'b1;
                end
                if (cmd_valid_q && cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    op_a_d      = '0;
                    op_b_d      = '0;
                    count_d     = '0;
                    state_d     = ENTER_A;
                end
            end

            default: begin
                state_d = ENTER_A;
            end
        endcase

`ifdef KEY_SEQUENCER_CHAIN_EN
        // A fresh result re-arms chaining even if a digit lands the same cycle.
        if (result_valid) begin
            chain_val_d  = result;
            chain_flag_d = 1'b1;
        end
`endif

        disp_d = (state_d == ENTER_A) ? op_a_d : op_b_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ENTER_A;
            op_a_q      <= '0;
            op_b_q      <= '0;
            disp_q      <= '0;
            count_q     <= '0;
            op_sel_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            strobe_q    <= 1'b0;
`ifdef KEY_SEQUENCER_CHAIN_EN
            chain_val_q  <= '0;
            chain_flag_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            disp_q      <= disp_d;
            count_q     <= count_d;
            op_sel_q    <= op_sel_d;
            cmd_valid_q <= cmd_valid_d;
            key_err_q   <= key_err_d;
            strobe_q    <= strobe_d;
`ifdef KEY_SEQUENCER_CHAIN_EN
            chain_val_q  <= chain_val_d;
            chain_flag_q <= chain_flag_d;
`endif
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_sel     = op_sel_q;
    assign disp_value = disp_q;
    assign key_err    = key_err_q;

endmodule

// File: doc/key_sequencer.md
Name: key_sequencer

Overview:
Operand-entry controller placed between the keypad encoder and the arithmetic datapath. It consumes the encoder's 4-bit keycode and level keystrobe, detects each new key press, and accumulates decimal digits into two binary operands. It also records the operator and, on Enter, issues one valid/ready command to the datapath. It owns all entry sequencing so the datapath only ever sees complete, stable commands.

Parameters:
NUM_DIGITS, 4, maximum decimal digits accepted per operand.
WIDTH, 16, operand width in bits; must satisfy 2**WIDTH > 10**NUM_DIGITS - 1.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
keycode  in  4  encoder code: 0-9 digit, 10 add, 11 sub, 12 enter, 15 multi-press; 13/14 unused.
keystrobe  in  1  high while a key is held (level).
cmd_valid  out  1  command available.
cmd_ready  in  1  datapath accepts command.
op_a  out  WIDTH  first operand, unsigned binary.
op_b  out  WIDTH  second operand, unsigned binary.
op_sel  out  1  0 = add, 1 = sub.
disp_value  out  WIDTH  operand currently being entered.
key_err  out  1  one-cycle pulse on a rejected key.

Behaviour:
- Reset (async, rst=1): state ENTER_A; op_a, op_b, disp_value, digit counter, op_sel, cmd_valid, key_err all 0; strobe history register = 0.
- Key event: strobe_q is keystrobe registered. event = keystrobe & ~strobe_q. keycode is sampled in the event cycle. Effects are visible after that rising edge (1-cycle latency). A held key produces exactly one event.
- States: ENTER_A, ENTER_B, ISSUE.
- ENTER_A:
  - digit d with count<NUM_DIGITS: op_a <= op_a*10 + d; count++.
  - add/sub: op_sel <= code-10; count <= 0; op_b <= 0; go to ENTER_B. A zero-digit operand is 0.
  - enter: ignored, no error.
- ENTER_B:
  - digit: accumulates into op_b under the same count rule.
  - add/sub: overwrites op_sel and stays in ENTER_B, so the last operator pressed wins.
  - enter: cmd_valid <= 1; go to ISSUE.
- ISSUE:
  - cmd_valid held high; op_a, op_b, op_sel held stable until cmd_valid & cmd_ready is sampled on a rising edge.
  - On that edge: cmd_valid <= 0, op_a <= 0, op_b <= 0, count <= 0; go to ENTER_A.
  - Every key event in ISSUE is dropped and pulses key_err.
  - cmd_ready while in another state has no effect.
- Rejected keys, each of which pulses key_err for 1 cycle with no state change:
  - a digit when count==NUM_DIGITS;
  - codes 13, 14, 15;
  - any key in ISSUE.
- disp_value = op_a in ENTER_A, op_b in ENTER_B and ISSUE; registered, updated on the same edge as the operand.
- Arithmetic: multiply-by-10 is shift-add in WIDTH bits. No overflow is possible given the parameter constraint.
- A key event coinciding with the handshake edge in ISSUE is dropped (key_err=1).
- rst asserted mid-ISSUE drops cmd_valid immediately; a command is never half-issued.

Optional Feature:
Macro KEY_SEQUENCER_CHAIN_EN.
- When defined, adds ports result (in, WIDTH) and result_valid (in, 1).
  - On result_valid, the controller latches result and sets a chain flag.
  - In ENTER_A, an add/sub pressed with count==0 and the chain flag set loads op_a <= latched result before moving to ENTER_B.
  - Any digit entered in ENTER_A clears the chain flag. Reset clears the flag and the latched result.
- When undefined, the ports are absent and a zero-digit A is always 0.

Test Plan:
- Reset: rst=1 mid-sequence -> every output 0, state ENTER_A, cmd_valid=0 asynchronously.
- Keys 1,2,add,3,4,enter (each held 3 cycles, released 2) -> cmd_valid=1, op_a=12, op_b=34, op_sel=0; disp_value shows 1, 12, 3, 34 in turn.
- Backpressure: cmd_ready=0 for 5 cycles with a key pressed during ISSUE -> operands stable, key_err one pulse; cmd_ready=1 -> handshake, next cycle cmd_valid=0 and op_a=0.
- Digits 9,9,9,9,9 with NUM_DIGITS=4 -> op_a=9999, key_err on the 5th digit; codes 15 and 13 -> key_err, no change.
- add then sub in ENTER_B, then 5, enter -> op_a=0, op_b=5, op_sel=1; a key held 10 cycles yields exactly one digit.
- CHAIN_EN: result=77 with result_valid, then sub,3,enter -> op_a=77, op_b=3, op_sel=1; repeat with digit 4 first -> op_a=4.
